// File: rtl/conv_stream_feeder_pkg.sv
// Shared accelerator definitions: feeder sequencer states, stream tags and the
// helper that picks the first non-empty tile phase.
package conv_stream_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_IFMAP,
    S_WEIGHT,
    S_DRAIN
  } state_t;

  localparam logic TAG_IFMAP  = 1'b1;
  localparam logic TAG_WEIGHT = 1'b0;

  // Zero-length phases are skipped; an all-empty tile set goes straight to DRAIN.
  function automatic state_t first_tile_phase(input logic no_tiles,
                                              input logic no_ifm,
                                              input logic no_wt);
    if (no_tiles) return S_DRAIN;
    if (!no_ifm)  return S_IFMAP;
    if (!no_wt)   return S_WEIGHT;
    return S_DRAIN;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry response buffer for one valid/ready stream; the producer must
// respect the credit given by level, so a push never lands on a full buffer.
module stream_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             vld,
  input  logic             rdy,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;

  assign vld  = (level != 2'd0);
  assign pop  = vld && rdy;
  assign data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, so the stream data output reads 0 during reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      level <= level + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/conv_stream_feeder.sv
// Layer feeder: reads config words, then per tile the ifmap and weight words,
// and streams them out through two credit-controlled 2-entry buffers.
module conv_stream_feeder
  import conv_stream_feeder_pkg::*;
#(
  parameter int IFMAP_WEIGHT_WIDTH = 8,
  parameter int FIFO_WORDS         = 2,
  parameter int CONFIG_ADDR_WIDTH  = 8,
  parameter int CONFIG_DATA_WIDTH  = 8,
  parameter int COUNTER_WIDTH      = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  input  logic [COUNTER_WIDTH-1:0]                  cfg_count,
  input  logic [COUNTER_WIDTH-1:0]                  ifm_words,
  input  logic [COUNTER_WIDTH-1:0]                  wt_words,
  input  logic [COUNTER_WIDTH-1:0]                  num_tiles,
  output logic                                      cfg_rd_en,
  output logic [CONFIG_ADDR_WIDTH-1:0]              cfg_rd_adr,
  input  logic [CONFIG_DATA_WIDTH-1:0]              cfg_rd_data,
  output logic                                      ifm_rd_en,
  output logic [COUNTER_WIDTH-1:0]                  ifm_rd_adr,
  output logic                                      wt_rd_en,
  output logic [COUNTER_WIDTH-1:0]                  wt_rd_adr,
  input  logic [FIFO_WORDS*IFMAP_WEIGHT_WIDTH-1:0]  rd_data,
  output logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] config_data,
  output logic                                      config_vld,
  input  logic                                      config_rdy,
  output logic [FIFO_WORDS*IFMAP_WEIGHT_WIDTH:0]    ifmap_weight_data,
  output logic                                      ifmap_weight_vld,
  input  logic                                      ifmap_weight_rdy
);

  localparam int DW = FIFO_WORDS * IFMAP_WEIGHT_WIDTH;
  localparam int CW = CONFIG_ADDR_WIDTH + CONFIG_DATA_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] cfg_len, ifm_len, wt_len, tiles_len;
  logic [COUNTER_WIDTH-1:0] cfg_cnt, ifm_cnt, ifm_adr, wt_adr, tile_cnt;
  logic                     cfg_inflight, dat_inflight, dat_tag;
  logic [CONFIG_ADDR_WIDTH-1:0] cfg_idx;
  logic [1:0]               cfg_level, dat_level;
  logic                     cfg_ok, dat_ok;
  logic                     cfg_last, ifm_last, wt_last, tile_last;

  // A slot freed by a pop this cycle may be re-credited at once, which keeps
  // one beat per cycle across the read-to-buffer latency.
  assign cfg_ok = (cfg_level + {1'b0, cfg_inflight} < 2'd2) || (config_vld && config_rdy);
  assign dat_ok = (dat_level + {1'b0, dat_inflight} < 2'd2) || (ifmap_weight_vld && ifmap_weight_rdy);

  assign cfg_rd_en  = (state == S_CONFIG) && cfg_ok;
  assign ifm_rd_en  = (state == S_IFMAP)  && dat_ok;
  assign wt_rd_en   = (state == S_WEIGHT) && dat_ok;
  assign cfg_rd_adr = cfg_cnt[CONFIG_ADDR_WIDTH-1:0];
  assign ifm_rd_adr = ifm_adr;
  assign wt_rd_adr  = wt_adr;

  assign cfg_last  = (cfg_cnt  == cfg_len   - ONE);
  assign ifm_last  = (ifm_cnt  == ifm_len   - ONE);
  assign wt_last   = (wt_adr   == wt_len    - ONE);
  assign tile_last = (tile_cnt == tiles_len - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_len      <= '0;
      ifm_len      <= '0;
      wt_len       <= '0;
      tiles_len    <= '0;
      cfg_cnt      <= '0;
      ifm_cnt      <= '0;
      ifm_adr      <= '0;
      wt_adr       <= '0;
      tile_cnt     <= '0;
      cfg_inflight <= 1'b0;
      dat_inflight <= 1'b0;
      dat_tag      <= TAG_WEIGHT;
      cfg_idx      <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the pre-edge register values.
      done         <= 1'b0;
      cfg_inflight <= cfg_rd_en;
      dat_inflight <= ifm_rd_en || wt_rd_en;
      if (cfg_rd_en) cfg_idx <= cfg_rd_adr;
      if (ifm_rd_en || wt_rd_en) dat_tag <= ifm_rd_en ? TAG_IFMAP : TAG_WEIGHT;

      case (state)
        S_IDLE: if (start) begin
          cfg_len   <= cfg_count;
          ifm_len   <= ifm_words;
          wt_len    <= wt_words;
          tiles_len <= num_tiles;
          cfg_cnt   <= '0;
          ifm_cnt   <= '0;
          ifm_adr   <= '0;
          wt_adr    <= '0;
          tile_cnt  <= '0;
          busy      <= 1'b1;
          state     <= (cfg_count != '0) ? S_CONFIG
                     : first_tile_phase(num_tiles == '0, ifm_words == '0, wt_words == '0);
        end
        S_CONFIG: if (cfg_rd_en) begin
          cfg_cnt <= cfg_cnt + ONE;
          if (cfg_last) state <= first_tile_phase(tiles_len == '0, ifm_len == '0, wt_len == '0);
        end
        S_IFMAP: if (ifm_rd_en) begin
          ifm_adr <= ifm_adr + ONE;
          if (!ifm_last) begin
            ifm_cnt <= ifm_cnt + ONE;
          end else begin
            ifm_cnt <= '0;
            if (wt_len != '0) state    <= S_WEIGHT;
            else if (tile_last) state  <= S_DRAIN;
            else tile_cnt              <= tile_cnt + ONE;
          end
        end
        S_WEIGHT: if (wt_rd_en) begin
          if (!wt_last) begin
            wt_adr <= wt_adr + ONE;
          end else begin
            wt_adr <= '0;
            if (tile_last) begin
              state <= S_DRAIN;
            end else begin
              tile_cnt <= tile_cnt + ONE;
              state    <= (ifm_len != '0) ? S_IFMAP : S_WEIGHT;
            end
          end
        end
        S_DRAIN: if (!cfg_inflight && !dat_inflight && cfg_level == 2'd0 && dat_level == 2'd0) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  stream_skid_fifo #(.WIDTH(CW)) u_cfg_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cfg_inflight),
    .push_data ({cfg_idx, cfg_rd_data}),
    .vld       (config_vld),
    .rdy       (config_rdy),
    .data      (config_data),
    .level     (cfg_level)
  );

  stream_skid_fifo #(.WIDTH(DW + 1)) u_dat_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dat_inflight),
    .push_data ({dat_tag, rd_data}),
    .vld       (ifmap_weight_vld),
    .rdy       (ifmap_weight_rdy),
    .data      (ifmap_weight_data),
    .level     (dat_level)
  );

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder with default parameters: memory models,
// a handshake logger and per-scenario expected sequences.
module tb_conv_stream_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic [31:0] cfg_count, ifm_words, wt_words, num_tiles;
  logic        cfg_rd_en;
  logic [7:0]  cfg_rd_adr;
  logic [7:0]  cfg_rd_data;
  logic        ifm_rd_en, wt_rd_en;
  logic [31:0] ifm_rd_adr, wt_rd_adr;
  logic [15:0] rd_data;
  logic [15:0] config_data;
  logic        config_vld, config_rdy;
  logic [16:0] ifmap_weight_data;
  logic        ifmap_weight_vld, ifmap_weight_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  conv_stream_feeder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .cfg_count         (cfg_count),
    .ifm_words         (ifm_words),
    .wt_words          (wt_words),
    .num_tiles         (num_tiles),
    .cfg_rd_en         (cfg_rd_en),
    .cfg_rd_adr        (cfg_rd_adr),
    .cfg_rd_data       (cfg_rd_data),
    .ifm_rd_en         (ifm_rd_en),
    .ifm_rd_adr        (ifm_rd_adr),
    .wt_rd_en          (wt_rd_en),
    .wt_rd_adr         (wt_rd_adr),
    .rd_data           (rd_data),
    .config_data       (config_data),
    .config_vld        (config_vld),
    .config_rdy        (config_rdy),
    .ifmap_weight_data (ifmap_weight_data),
    .ifmap_weight_vld  (ifmap_weight_vld),
    .ifmap_weight_rdy  (ifmap_weight_rdy)
  );

  always #5 clk = ~clk;

  // Memory models: config word = addr ^ A5, ifmap word = 1000+addr, weight word = B000+addr.
  always @(posedge clk) begin
    if (cfg_rd_en) cfg_rd_data <= cfg_rd_adr ^ 8'hA5;
    if (ifm_rd_en)     rd_data <= 16'h1000 + ifm_rd_adr[15:0];
    else if (wt_rd_en) rd_data <= 16'hB000 + wt_rd_adr[15:0];
  end

  bit bp_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      ifmap_weight_rdy = ~ifmap_weight_rdy;
      config_rdy       = ~config_rdy;
    end
  end

  logic [15:0] got_cfg_q[$];
  logic [16:0] got_dat_q[$];
  logic [31:0] got_ifm_adr_q[$];
  logic [31:0] got_wt_adr_q[$];
  logic [15:0] exp_cfg_q[$];
  logic [16:0] exp_dat_q[$];
  logic [31:0] exp_ifm_adr_q[$];
  logic [31:0] exp_wt_adr_q[$];
  int          done_cnt, onehot_err, stall_err;
  logic        cfg_stall = 1'b0, dat_stall = 1'b0;
  logic [15:0] cfg_hold;
  logic [16:0] dat_hold;

  always @(negedge clk) begin
    if (!rst_n) begin
      cfg_stall = 1'b0;
      dat_stall = 1'b0;
    end else begin
      if (config_vld && config_rdy)             got_cfg_q.push_back(config_data);
      if (ifmap_weight_vld && ifmap_weight_rdy) got_dat_q.push_back(ifmap_weight_data);
      if (ifm_rd_en) got_ifm_adr_q.push_back(ifm_rd_adr);
      if (wt_rd_en)  got_wt_adr_q.push_back(wt_rd_adr);
      if (done) done_cnt++;
      if (int'(cfg_rd_en) + int'(ifm_rd_en) + int'(wt_rd_en) > 1) onehot_err++;
      if (cfg_stall && (!config_vld || config_data != cfg_hold)) stall_err++;
      if (dat_stall && (!ifmap_weight_vld || ifmap_weight_data != dat_hold)) stall_err++;
      cfg_stall = config_vld && !config_rdy;
      cfg_hold  = config_data;
      dat_stall = ifmap_weight_vld && !ifmap_weight_rdy;
      dat_hold  = ifmap_weight_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    got_cfg_q.delete(); got_dat_q.delete();
    got_ifm_adr_q.delete(); got_wt_adr_q.delete();
    exp_cfg_q.delete(); exp_dat_q.delete();
    exp_ifm_adr_q.delete(); exp_wt_adr_q.delete();
    done_cnt = 0; onehot_err = 0; stall_err = 0;
  endtask

  task automatic build_expected(input int c, input int iw, input int ww, input int t);
    logic [7:0]  idx;
    logic [31:0] a = 0;
    for (int i = 0; i < c; i++) begin
      idx = 8'(i);
      exp_cfg_q.push_back({idx, idx ^ 8'hA5});
    end
    for (int k = 0; k < t; k++) begin
      for (int w = 0; w < iw; w++) begin
        exp_dat_q.push_back({1'b1, 16'h1000 + a[15:0]});
        exp_ifm_adr_q.push_back(a);
        a++;
      end
      for (int w = 0; w < ww; w++) begin
        exp_dat_q.push_back({1'b0, 16'hB000 + 16'(w)});
        exp_wt_adr_q.push_back(32'(w));
      end
    end
  endtask

  task automatic compare_logs(input string p);
    check({p, "_cfg_beats"}, got_cfg_q.size(), exp_cfg_q.size());
    for (int i = 0; i < exp_cfg_q.size() && i < got_cfg_q.size(); i++)
      check($sformatf("%s_cfg%0d", p, i), got_cfg_q[i], exp_cfg_q[i]);
    check({p, "_dat_beats"}, got_dat_q.size(), exp_dat_q.size());
    for (int i = 0; i < exp_dat_q.size() && i < got_dat_q.size(); i++)
      check($sformatf("%s_dat%0d", p, i), got_dat_q[i], exp_dat_q[i]);
    check({p, "_ifm_reads"}, got_ifm_adr_q.size(), exp_ifm_adr_q.size());
    for (int i = 0; i < exp_ifm_adr_q.size() && i < got_ifm_adr_q.size(); i++)
      check($sformatf("%s_ifm_adr%0d", p, i), got_ifm_adr_q[i], exp_ifm_adr_q[i]);
    check({p, "_wt_reads"}, got_wt_adr_q.size(), exp_wt_adr_q.size());
    for (int i = 0; i < exp_wt_adr_q.size() && i < got_wt_adr_q.size(); i++)
      check($sformatf("%s_wt_adr%0d", p, i), got_wt_adr_q[i], exp_wt_adr_q[i]);
    check({p, "_done_pulses"}, done_cnt, 1);
    check({p, "_onehot_err"}, onehot_err, 0);
    check({p, "_stall_err"}, stall_err, 0);
  endtask

  task automatic check_zero(input string p);
    check({p, "_ctrl"}, {busy, done, config_vld, ifmap_weight_vld, cfg_rd_en, ifm_rd_en, wt_rd_en}, 0);
    check({p, "_cfg_adr"}, cfg_rd_adr, 0);
    check({p, "_ifm_adr"}, ifm_rd_adr, 0);
    check({p, "_wt_adr"}, wt_rd_adr, 0);
    check({p, "_cfg_data"}, config_data, 0);
    check({p, "_iw_data"}, ifmap_weight_data, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after start was sampled.
  task automatic start_xfer(input int c, input int iw, input int ww, input int t);
    cfg_count = c; ifm_words = iw; wt_words = ww; num_tiles = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string p);
    bit seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    check({p, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    check({p, "_done_one_cycle"}, done, 0);
    check({p, "_busy_cleared"}, busy, 0);
  endtask

  initial begin
    int lat;
    bit reached;
    rst_n = 1'b0; start = 1'b0;
    config_rdy = 1'b1; ifmap_weight_rdy = 1'b1;
    cfg_count = 0; ifm_words = 0; wt_words = 0; num_tiles = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("after_reset");

    // Normal flow with full throughput.
    clear_logs();
    build_expected(35, 2, 3, 2);
    start_xfer(35, 2, 3, 2);
    check("normal_busy", busy, 1);
    lat = 0;
    while (!config_vld && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("normal_latency", lat, 2);
    wait_done("normal");
    compare_logs("normal");

    // Backpressure on both streams, toggling every cycle.
    clear_logs();
    build_expected(3, 2, 3, 2);
    bp_mode = 1'b1;
    @(posedge clk); #1;
    start_xfer(3, 2, 3, 2);
    wait_done("bp");
    #2;
    bp_mode = 1'b0;
    config_rdy = 1'b1; ifmap_weight_rdy = 1'b1;
    @(posedge clk); #1;
    compare_logs("bp");

    // Zero tiles: config only.
    clear_logs();
    build_expected(4, 2, 3, 0);
    start_xfer(4, 2, 3, 0);
    wait_done("zero_tiles");
    compare_logs("zero_tiles");

    // Reset during the weight phase, then replay from config index 0.
    clear_logs();
    start_xfer(3, 2, 3, 2);
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (got_wt_adr_q.size() > 0) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rst_mid_reached_weight", reached, 1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    build_expected(3, 1, 1, 1);
    start_xfer(3, 1, 1, 1);
    wait_done("replay");
    compare_logs("replay");

    // Start pulsed again while in IFMAP must be ignored.
    clear_logs();
    build_expected(2, 2, 1, 2);
    start_xfer(2, 2, 1, 2);
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (got_ifm_adr_q.size() > 0) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("busy_start_reached_ifmap", reached, 1);
    start_xfer(9, 1, 1, 1);
    wait_done("busy_start");
    compare_logs("busy_start");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
